// File: rtl/vga_pkg.sv
// Shared constants for the text-mode video path.
//  - Screen geometry (80x30 cells) and the VRAM word layout.
//  - BLANK_CELL: the word the screen-clear engine writes (space, grey on black).
//  - clr_state_t: states of the clear engine inside vram_arbiter.
package vga_pkg;

    localparam int VGA_COLS   = 80;
    localparam int VGA_ROWS   = 30;
    localparam int VRAM_AW    = 12;
    localparam int VRAM_DW    = 16;
    localparam int VRAM_CELLS = VGA_COLS * VGA_ROWS;

    localparam logic [VRAM_DW-1:0] BLANK_CELL = 16'h0720;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

endpackage

// File: rtl/vram_rd_tag_pipe.sv
// Read return pipeline for the VRAM arbiter.
//  Every read issued to the RAM (or a CPU read that bypasses the RAM because its
//  address is out of range) carries a tag {disp, cpu, oor}. Stage 1 waits for
//  the RAM's one-cycle read latency, stage 2 registers ram_rdata into the
//  requester's data register, giving a fixed 2-cycle return.
// Ports:
//  clk, reset            clock, asynchronous active-low reset
//  rd_disp, rd_cpu       read issued this cycle for display / CPU
//  rd_oor                CPU read was out of range: return zero, not RAM data
//  ram_rdata             RAM read data (valid one cycle after the read)
//  disp_valid, disp_data display return (data holds while valid is low)
//  cpu_rvalid, cpu_rdata CPU return (data holds while valid is low)
module vram_rd_tag_pipe
    import vga_pkg::*;
#(
    parameter int DW = VRAM_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          rd_disp,
    input  logic          rd_cpu,
    input  logic          rd_oor,
    input  logic [DW-1:0] ram_rdata,
    output logic          disp_valid,
    output logic [DW-1:0] disp_data,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata
);

    logic disp_p1;
    logic cpu_p1;
    logic oor_p1;

    // Stage 1: tag waits while the RAM performs the read
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_p1 <= 1'b0;
            cpu_p1  <= 1'b0;
            oor_p1  <= 1'b0;
        end else begin
            disp_p1 <= rd_disp;
            cpu_p1  <= rd_cpu;
            oor_p1  <= rd_oor;
        end
    end

    // Stage 2: capture RAM data for the tagged requester
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            disp_valid <= 1'b0;
            disp_data  <= '0;
            cpu_rvalid <= 1'b0;
            cpu_rdata  <= '0;
        end else begin
            disp_valid <= disp_p1;
            cpu_rvalid <= cpu_p1;
            if (disp_p1) begin
                disp_data <= ram_rdata;
            end
            if (cpu_p1) begin
                cpu_rdata <= oor_p1 ? '0 : ram_rdata;
            end
        end
    end

endmodule

// File: rtl/vram_arbiter.sv
// Single-port text-mode VRAM arbiter.
//  Per-cycle priority: display fetch, then CPU, then the screen-clear engine,
//  which only uses cycles nobody else asked for. CPU requests outside the
//  screen are accepted but never reach the RAM; such reads return zero.
// Ports:
//  clk, reset                            clock, asynchronous active-low reset
//  disp_req, disp_addr                   display fetch (always granted)
//  disp_valid, disp_data                 display return, 2 cycles later
//  cpu_valid, cpu_we, cpu_addr, cpu_wdata CPU request (valid/ready)
//  cpu_ready                             CPU request accepted this cycle
//  cpu_rvalid, cpu_rdata                 CPU read return, 2 cycles later
//  clr_start, clr_busy, clr_done         screen-clear control and status
//  ram_en, ram_we, ram_addr, ram_wdata   RAM request
//  ram_rdata                             RAM read data, 1 cycle latency
module vram_arbiter
    import vga_pkg::*;
#(
    parameter int             AW    = VRAM_AW,
    parameter int             DW    = VRAM_DW,
    parameter int             CELLS = VRAM_CELLS,
    parameter logic [DW-1:0]  FILL  = BLANK_CELL
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    output logic          disp_valid,
    output logic [DW-1:0] disp_data,
    input  logic          cpu_valid,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_ready,
    output logic          cpu_rvalid,
    output logic [DW-1:0] cpu_rdata,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata
);

    localparam logic [AW-1:0] LAST_CELL = AW'(CELLS - 1);

    clr_state_t    state;
    logic [AW-1:0] clr_addr;
    logic          cpu_in_range;
    logic          clr_grant;
    logic          rd_disp;
    logic          rd_cpu;
    logic          rd_oor;

    assign cpu_in_range = (cpu_addr <= LAST_CELL);

    // Grant mux. Everything is gated by reset so all outputs sit at zero while
    // reset is held, even though the request inputs may still be active.
    always_comb begin
        cpu_ready = 1'b0;
        clr_grant = 1'b0;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        rd_disp   = 1'b0;
        rd_cpu    = 1'b0;
        rd_oor    = 1'b0;
        if (reset) begin
            if (disp_req) begin
                ram_en   = 1'b1;
                ram_addr = disp_addr;
                rd_disp  = 1'b1;
            end else if (cpu_valid) begin
                cpu_ready = 1'b1;
                rd_cpu    = ~cpu_we;
                rd_oor    = ~cpu_we & ~cpu_in_range;
                if (cpu_in_range) begin
                    ram_en    = 1'b1;
                    ram_we    = cpu_we;
                    ram_addr  = cpu_addr;
                    ram_wdata = cpu_we ? cpu_wdata : '0;
                end
            end else if (state == CLEAR) begin
                clr_grant = 1'b1;
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_addr  = clr_addr;
                ram_wdata = FILL;
            end
        end
    end

    // Clear engine: walks clr_addr over the screen, advancing only on granted
    // cycles, so the clear always writes every cell exactly once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            clr_addr <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    if (clr_grant) begin
                        if (clr_addr == LAST_CELL) begin
                            state    <= IDLE;
                            clr_addr <= '0;
                            clr_busy <= 1'b0;
                            clr_done <= 1'b1;
                        end else begin
                            clr_addr <= clr_addr + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    vram_rd_tag_pipe #(
        .DW(DW)
    ) u_rd_pipe (
        .clk       (clk),
        .reset     (reset),
        .rd_disp   (rd_disp),
        .rd_cpu    (rd_cpu),
        .rd_oor    (rd_oor),
        .ram_rdata (ram_rdata),
        .disp_valid(disp_valid),
        .disp_data (disp_data),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata (cpu_rdata)
    );

endmodule

// File: tb/tb_vram_arbiter.sv
// Bench for vram_arbiter: a behavioural RAM, a reference model of the screen
// contents and of the return timing, directed scenarios and a random phase.
`timescale 1ns/1ps
module tb_vram_arbiter;

    localparam int AW    = 12;
    localparam int DW    = 16;
    localparam int CELLS = 2400;
    localparam logic [DW-1:0] FILL = 16'h0720;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          disp_req = 1'b0;
    logic [AW-1:0] disp_addr = '0;
    logic          disp_valid;
    logic [DW-1:0] disp_data;
    logic          cpu_valid = 1'b0;
    logic          cpu_we = 1'b0;
    logic [AW-1:0] cpu_addr = '0;
    logic [DW-1:0] cpu_wdata = '0;
    logic          cpu_ready;
    logic          cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          clr_start = 1'b0;
    logic          clr_busy;
    logic          clr_done;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic [DW-1:0] ram_rdata = '0;

    always #5 clk = ~clk;

    vram_arbiter dut (
        .clk(clk), .reset(reset),
        .disp_req(disp_req), .disp_addr(disp_addr),
        .disp_valid(disp_valid), .disp_data(disp_data),
        .cpu_valid(cpu_valid), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ready(cpu_ready),
        .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    // Behavioural single-port RAM, zero at start
    logic [DW-1:0] vmem [0:4095] = '{default: 16'h0000};
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) vmem[ram_addr] <= ram_wdata;
            else        ram_rdata      <= vmem[ram_addr];
        end
    end

    // Reference model
    logic [DW-1:0] ref_mem [0:4095] = '{default: 16'h0000};
    bit            rq_dv [4];
    logic [DW-1:0] rq_dd [4];
    bit            rq_cv [4];
    logic [DW-1:0] rq_cd [4];
    logic [DW-1:0] hold_dd = '0;
    logic [DW-1:0] hold_cd = '0;
    bit            m_busy = 1'b0;
    bit            m_done = 1'b0;
    int            m_idx = 0;
    int            cyc = 0;

    int checks = 0;
    int failures = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int clr_wr_cnt = 0;
    logic [DW-1:0] last_cpu_rdata = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            rq_dv[i] = 1'b0;
            rq_cv[i] = 1'b0;
        end
        hold_dd = '0;
        hold_cd = '0;
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_idx   = 0;
    endtask

    // One clock with the inputs currently applied: check at negedge, advance model
    task automatic step();
        bit acc, grant, in_rng, exp_en, exp_we;
        int slot, nslot;
        logic [AW-1:0] exp_addr;
        logic [DW-1:0] exp_wd;
        @(negedge clk);
        slot   = cyc % 4;
        nslot  = (cyc + 2) % 4;
        in_rng = (int'(cpu_addr) < CELLS);
        acc    = cpu_valid && !disp_req;
        grant  = m_busy && !disp_req && !cpu_valid;
        if (rq_dv[slot]) hold_dd = rq_dd[slot];
        if (rq_cv[slot]) hold_cd = rq_cd[slot];
        check_eq("cpu_ready", 32'(cpu_ready), 32'(acc));
        check_eq("disp_valid", 32'(disp_valid), 32'(rq_dv[slot]));
        check_eq("disp_data", 32'(disp_data), 32'(hold_dd));
        check_eq("cpu_rvalid", 32'(cpu_rvalid), 32'(rq_cv[slot]));
        check_eq("cpu_rdata", 32'(cpu_rdata), 32'(hold_cd));
        check_eq("clr_busy", 32'(clr_busy), 32'(m_busy));
        check_eq("clr_done", 32'(clr_done), 32'(m_done));
        exp_en = disp_req || (acc && in_rng) || grant;
        exp_we = (!disp_req && acc && cpu_we && in_rng) || grant;
        exp_addr = disp_req ? disp_addr : (acc ? cpu_addr : AW'(m_idx));
        exp_wd   = grant ? FILL : cpu_wdata;
        check_eq("ram_en", 32'(ram_en), 32'(exp_en));
        check_eq("ram_we", 32'(ram_we), 32'(exp_we));
        if (exp_en) check_eq("ram_addr", 32'(ram_addr), 32'(exp_addr));
        if (exp_we) check_eq("ram_wdata", 32'(ram_wdata), 32'(exp_wd));
        if (cpu_rvalid) last_cpu_rdata = cpu_rdata;
        if (clr_busy) busy_cnt++;
        if (clr_done) done_cnt++;
        if (clr_busy && ram_en && ram_we && !disp_req && !cpu_valid && ram_wdata == FILL)
            clr_wr_cnt++;
        // advance the model to the next cycle
        rq_dv[slot] = 1'b0;
        rq_cv[slot] = 1'b0;
        if (disp_req) begin
            rq_dv[nslot] = 1'b1;
            rq_dd[nslot] = ref_mem[disp_addr];
        end else if (acc) begin
            if (cpu_we) begin
                if (in_rng) ref_mem[cpu_addr] = cpu_wdata;
            end else begin
                rq_cv[nslot] = 1'b1;
                rq_cd[nslot] = in_rng ? ref_mem[cpu_addr] : '0;
            end
        end
        m_done = 1'b0;
        if (grant) begin
            ref_mem[m_idx] = FILL;
            if (m_idx == CELLS - 1) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
            m_idx++;
        end else if (!m_busy && clr_start) begin
            m_busy = 1'b1;
            m_idx  = 0;
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Hold reset for n cycles; every output must read zero throughout
    task automatic hold_reset(input int n);
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check_eq("rst_outs",
                     32'({cpu_ready, disp_valid, cpu_rvalid, clr_busy, clr_done, ram_en, ram_we}), 32'd0);
            check_eq("rst_data", 32'({disp_data, cpu_rdata}), 32'd0);
            check_eq("rst_ram", 32'({ram_addr, ram_wdata}), 32'd0);
            @(posedge clk);
            #1;
            cyc++;
        end
        reset = 1'b1;
    endtask

    // Issue one CPU request and hold it until accepted (bounded)
    task automatic cpu_xfer(input bit we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit done;
        done = 1'b0;
        cpu_valid = 1'b1;
        cpu_we    = we;
        cpu_addr  = a;
        cpu_wdata = d;
        for (int i = 0; i < 50 && !done; i++) begin
            done = !disp_req;
            step();
        end
        check_eq("cpu_accept", 32'(done), 32'd1);
        cpu_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bit acc_now;
        int idx_at_write;
        logic [DW-1:0] exp10;

        model_reset();
        #1;
        hold_reset(3);

        // Preload part of the screen with random words
        for (int i = 0; i < 100; i++) cpu_xfer(1'b1, AW'(i), 16'($urandom));
        idle(2);

        // T1: display owns every cycle, the CPU waits
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd3;
        disp_req = 1'b1;
        for (int i = 0; i < 80; i++) begin
            disp_addr = AW'(i);
            step();
        end
        disp_req = 1'b0;
        step();
        cpu_valid = 1'b0;
        idle(3);

        // T2: write then read back
        cpu_xfer(1'b1, 12'd5, 16'h1241);
        cpu_xfer(1'b0, 12'd5, 16'h0000);
        idle(2);
        check_eq("t2_readback", 32'(last_cpu_rdata), 32'h1241);

        // T5: out-of-range read returns zero without touching the RAM
        cpu_xfer(1'b1, 12'd6, 16'hBEEF);
        cpu_xfer(1'b0, 12'd6, 16'h0000);
        idle(2);
        cpu_xfer(1'b0, 12'd2400, 16'h0000);
        idle(2);
        check_eq("t5_oor_rdata", 32'(last_cpu_rdata), 32'h0);

        // T3: undisturbed clear
        busy_cnt = 0; done_cnt = 0;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int i = 0; i < 3000 && done_cnt == 0; i++) step();
        idle(3);
        check_eq("t3_busy_cycles", 32'(busy_cnt), 32'd2400);
        check_eq("t3_done_pulses", 32'(done_cnt), 32'd1);
        cpu_xfer(1'b0, 12'd2399, 16'h0000);
        idle(2);
        check_eq("t3_cell_2399", 32'(last_cpu_rdata), 32'(FILL));

        // T4: clear with half the cycles taken by the display and one CPU write
        for (int i = 0; i < 20; i++) cpu_xfer(1'b1, AW'(i), 16'($urandom));
        clr_wr_cnt = 0; done_cnt = 0;
        idx_at_write = -1;
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        for (int k = 0; k < 10000 && done_cnt == 0; k++) begin
            disp_req  = (k % 2 == 0);
            disp_addr = AW'($urandom_range(0, CELLS - 1));
            if (k == 15) begin
                cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 12'd10; cpu_wdata = 16'hABCD;
            end
            acc_now = cpu_valid && !disp_req;
            if (acc_now) idx_at_write = m_idx;
            step();
            if (acc_now) cpu_valid = 1'b0;
        end
        disp_req = 1'b0;
        idle(3);
        check_eq("t4_clear_writes", 32'(clr_wr_cnt), 32'd2400);
        check_eq("t4_done_pulses", 32'(done_cnt), 32'd1);
        exp10 = (idx_at_write > 10) ? 16'hABCD : FILL;
        cpu_xfer(1'b0, 12'd10, 16'h0000);
        idle(2);
        check_eq("t4_cell_10", 32'(last_cpu_rdata), 32'(exp10));

        // Random traffic, including occasional clears and out-of-range accesses
        for (int k = 0; k < 3000; k++) begin
            disp_req  = ($urandom_range(0, 3) == 0);
            disp_addr = AW'($urandom_range(0, CELLS - 1));
            clr_start = ($urandom_range(0, 599) == 0);
            acc_now   = cpu_valid && !disp_req;
            step();
            clr_start = 1'b0;
            if (acc_now || !cpu_valid) begin
                if ($urandom_range(0, 1) == 1) begin
                    cpu_valid = 1'b1;
                    cpu_we    = 1'($urandom_range(0, 1));
                    cpu_addr  = ($urandom_range(0, 7) == 0) ? AW'($urandom_range(CELLS, 4095))
                                                            : AW'($urandom_range(0, CELLS - 1));
                    cpu_wdata = 16'($urandom);
                end else begin
                    cpu_valid = 1'b0;
                end
            end
        end
        disp_req = 1'b0;
        cpu_valid = 1'b0;
        for (int i = 0; i < 3000 && m_busy; i++) step();
        idle(3);

        // T6: reset mid-clear with two reads in flight
        clr_start = 1'b1;
        step();
        clr_start = 1'b0;
        idle(40);
        cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 12'd7;
        step();
        cpu_valid = 1'b0;
        disp_req = 1'b1; disp_addr = 12'd8;
        hold_reset(4);
        disp_req = 1'b0;
        idle(5);
        check_eq("t6_idle_after_reset", 32'(clr_busy), 32'd0);
        cpu_xfer(1'b0, 12'd5, 16'h0000);
        idle(2);
        check_eq("t6_read_after_reset", 32'(last_cpu_rdata), 32'(ref_mem[5]));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
